// File: rtl/instr_fetch_pkg.sv
// Shared fetch-stage definitions: fault-cause codes, FSM encoding, slot layout
// and the PC legality check used by the PC generator.
package instr_fetch_pkg;

  localparam int INSTR_W = 32;

  typedef enum logic [1:0] {
    FC_NONE     = 2'b00,
    FC_MISALIGN = 2'b01,
    FC_RANGE    = 2'b10
  } fault_cause_e;

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_FAULT = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [31:0]        pc;
    logic [31:0]        pc_plus4;
  } fetch_slot_t;

  // Misalignment wins over range so the cause reflects the first broken rule.
  function automatic fault_cause_e pc_check(input logic [31:0] pc,
                                            input logic [31:0] last_word);
    fault_cause_e cause;
    if (pc[1:0] != 2'b00) begin
      cause = FC_MISALIGN;
    end else if (pc > last_word) begin
      cause = FC_RANGE;
    end else begin
      cause = FC_NONE;
    end
    return cause;
  endfunction

endpackage

// File: rtl/instr_fetch_pc_gen.sv
// PC register with reset/redirect/+4/hold selection and the legality check
// of the PC currently presented to instruction memory.
module fetch_pc_gen
  import instr_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          MEM_BYTES = 400
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         redirect_valid,
  input  logic [31:0]  redirect_pc,
  input  logic         advance,
  output logic [31:0]  pc,
  output fault_cause_e pc_cause
);

  localparam logic [31:0] LAST_WORD = 32'(MEM_BYTES - 4);

  logic [31:0] pc_r;
  logic [31:0] pc_next_s;

  // Next-PC selection; redirect outranks sequential advance.
  always_comb begin
    pc_next_s = pc_r;
    if (redirect_valid) begin
      pc_next_s = redirect_pc;
    end else if (advance) begin
      pc_next_s = pc_r + 32'd4;
    end else begin
      pc_next_s = pc_r;
    end
  end

  // PC register.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r <= RESET_PC;
    end else begin
      pc_r <= pc_next_s;
    end
  end

  assign pc       = pc_r;
  assign pc_cause = pc_check(pc_r, LAST_WORD);

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: presents the PC to instruction memory and holds the
// returned word in a registered slot for decode, with flush and fault handling.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          MEM_BYTES = 400
) (
  input  logic               clk,
  input  logic               rst,
  output logic [31:0]        imem_addr,
  input  logic [INSTR_W-1:0] imem_instr,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [31:0]        out_pc,
  output logic [31:0]        out_pc_plus4,
  output logic               fault,
  output logic [1:0]         fault_cause
);

  fetch_state_e state_r;
  fetch_state_e state_next_s;
  fetch_slot_t  slot_r;
  logic         out_valid_r;
  logic         fault_r;
  fault_cause_e fault_cause_r;

  logic         adv_s;
  logic         capture_s;
  logic         fault_set_s;
  logic [31:0]  pc_s;
  fault_cause_e pc_cause_s;

  fetch_pc_gen #(
    .RESET_PC  (RESET_PC),
    .MEM_BYTES (MEM_BYTES)
  ) u_pc_gen (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .advance        (capture_s),
    .pc             (pc_s),
    .pc_cause       (pc_cause_s)
  );

  assign adv_s = !out_valid_r || out_ready;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_RUN;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next state; a redirect always returns to RUN.
  always_comb begin
    state_next_s = state_r;
    if (redirect_valid) begin
      state_next_s = ST_RUN;
    end else begin
      case (state_r)
        ST_RUN: begin
          if (adv_s && (pc_cause_s != FC_NONE)) begin
            state_next_s = ST_FAULT;
          end else begin
            state_next_s = ST_RUN;
          end
        end
        ST_FAULT: state_next_s = ST_FAULT;
        default:  state_next_s = ST_RUN;
      endcase
    end
  end

  // FSM output strobes: capture a legal word or raise a fault when the slot can move.
  always_comb begin
    capture_s   = 1'b0;
    fault_set_s = 1'b0;
    if (redirect_valid) begin
      capture_s   = 1'b0;
      fault_set_s = 1'b0;
    end else begin
      case (state_r)
        ST_RUN: begin
          if (adv_s) begin
            if (pc_cause_s == FC_NONE) begin
              capture_s = 1'b1;
            end else begin
              fault_set_s = 1'b1;
            end
          end else begin
            capture_s   = 1'b0;
            fault_set_s = 1'b0;
          end
        end
        default: begin
          capture_s   = 1'b0;
          fault_set_s = 1'b0;
        end
      endcase
    end
  end

  // Fetch slot and sticky fault registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_r        <= '{instr: 32'h0, pc: 32'h0, pc_plus4: 32'h0};
      out_valid_r   <= 1'b0;
      fault_r       <= 1'b0;
      fault_cause_r <= FC_NONE;
    end else if (redirect_valid) begin
      out_valid_r   <= 1'b0;
      fault_r       <= 1'b0;
      fault_cause_r <= FC_NONE;
    end else if (capture_s) begin
      slot_r      <= '{instr: imem_instr, pc: pc_s, pc_plus4: pc_s + 32'd4};
      out_valid_r <= 1'b1;
    end else if (fault_set_s) begin
      out_valid_r   <= 1'b0;
      fault_r       <= 1'b1;
      fault_cause_r <= pc_cause_s;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  assign imem_addr    = pc_s;
  assign out_valid    = out_valid_r;
  assign out_instr    = slot_r.instr;
  assign out_pc       = slot_r.pc;
  assign out_pc_plus4 = slot_r.pc_plus4;
  assign fault        = fault_r;
  assign fault_cause  = fault_cause_r;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed vector table for the scripted
// scenarios, then randomized traffic against a behavioural fetch model.
module tb_instr_fetch;

  localparam int MEMB = 400;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] out_pc_plus4;
  logic        fault;
  logic [1:0]  fault_cause;

  logic [31:0] mem [0:99];
  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  instr_fetch #(.RESET_PC(32'h0000_0000), .MEM_BYTES(MEMB)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .out_pc_plus4   (out_pc_plus4),
    .fault          (fault),
    .fault_cause    (fault_cause)
  );

  always_comb begin
    if (imem_addr < 32'd400) imem_instr = mem[imem_addr[8:2]];
    else                     imem_instr = 32'hFFFF_FFFF;
  end

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (a < 32'd400) return mem[a[8:2]];
    else             return 32'hFFFF_FFFF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply one cycle of inputs at the falling edge; return at the next falling edge.
  task automatic tick(input logic r, input logic rv, input logic [31:0] rpc, input logic rdy);
    rst = r; redirect_valid = rv; redirect_pc = rpc; out_ready = rdy;
    @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    logic r; logic rv; logic [31:0] rpc; logic rdy;
    logic ev; logic [31:0] epc; logic [31:0] einstr; logic [31:0] ep4;
    logic [31:0] eaddr; logic ef; logic [1:0] ec; logic cd;
  } vec_t;

  function automatic vec_t v(logic r, logic rv, logic [31:0] rpc, logic rdy,
                             logic ev, logic [31:0] epc, logic [31:0] ei, logic [31:0] ep4,
                             logic [31:0] ea, logic ef, logic [1:0] ec, logic cd);
    vec_t x;
    x = '{r, rv, rpc, rdy, ev, epc, ei, ep4, ea, ef, ec, cd};
    return x;
  endfunction

  // Behavioural reference state (slot contents, PC, sticky fault).
  logic        m_valid, m_fault;
  logic [1:0]  m_cause;
  logic [31:0] m_pc, m_spc, m_sinstr;

  task automatic model_step(input logic r, input logic rv, input logic [31:0] rpc, input logic rdy);
    if (r) begin
      m_pc = 32'h0; m_valid = 1'b0; m_fault = 1'b0; m_cause = 2'd0;
      m_spc = 32'h0; m_sinstr = 32'h0;
    end else if (rv) begin
      m_pc = rpc; m_valid = 1'b0; m_fault = 1'b0; m_cause = 2'd0;
    end else if (!m_fault && (!m_valid || rdy)) begin
      if (m_pc % 4 != 0) begin
        m_fault = 1'b1; m_cause = 2'd1; m_valid = 1'b0;
      end else if (m_pc > MEMB - 4) begin
        m_fault = 1'b1; m_cause = 2'd2; m_valid = 1'b0;
      end else begin
        m_sinstr = mem_rd(m_pc); m_spc = m_pc; m_valid = 1'b1; m_pc = m_pc + 4;
      end
    end
  endtask

  initial begin
    vec_t vt[$];
    logic [31:0] tgt;
    logic r, rv, rdy;

    for (int i = 0; i < 100; i++) mem[i] = 32'hA000_0000 | (i * 4);
    mem[0] = 32'h1111_1111; mem[1] = 32'h2222_2222; mem[2] = 32'h3333_3333;
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0; out_ready = 1'b0;
    @(negedge clk);

    //            r rv rpc      rdy ev epc      einstr        ep4      eaddr    ef ec  cd
    vt.push_back(v(1,0,32'h0,   1, 0,32'h0,   32'h0,        32'h0,   32'h0,   0,2'd0,1));
    vt.push_back(v(0,0,32'h0,   1, 1,32'h0,   32'h1111_1111,32'h4,   32'h4,   0,2'd0,1));
    vt.push_back(v(0,0,32'h0,   1, 1,32'h4,   32'h2222_2222,32'h8,   32'h8,   0,2'd0,1));
    for (int i = 0; i < 3; i++)
      vt.push_back(v(0,0,32'h0, 0, 1,32'h4,   32'h2222_2222,32'h8,   32'h8,   0,2'd0,1));
    vt.push_back(v(0,0,32'h0,   1, 1,32'h8,   32'h3333_3333,32'hC,   32'hC,   0,2'd0,1));
    vt.push_back(v(0,0,32'h0,   0, 1,32'h8,   32'h3333_3333,32'hC,   32'hC,   0,2'd0,1));
    vt.push_back(v(0,1,32'h40,  0, 0,32'h0,   32'h0,        32'h0,   32'h40,  0,2'd0,0));
    vt.push_back(v(0,0,32'h0,   0, 1,32'h40,  32'hA000_0040,32'h44,  32'h44,  0,2'd0,1));
    vt.push_back(v(0,1,32'h42,  1, 0,32'h0,   32'h0,        32'h0,   32'h42,  0,2'd0,0));
    for (int i = 0; i < 6; i++)
      vt.push_back(v(0,0,32'h0, 1, 0,32'h0,   32'h0,        32'h0,   32'h42,  1,2'd1,0));
    vt.push_back(v(1,0,32'h0,   1, 0,32'h0,   32'h0,        32'h0,   32'h0,   0,2'd0,1));
    vt.push_back(v(0,1,32'd392, 1, 0,32'h0,   32'h0,        32'h0,   32'd392, 0,2'd0,0));
    vt.push_back(v(0,0,32'h0,   1, 1,32'd392, 32'hA000_0188,32'd396, 32'd396, 0,2'd0,1));
    vt.push_back(v(0,0,32'h0,   1, 1,32'd396, 32'hA000_018C,32'd400, 32'd400, 0,2'd0,1));
    vt.push_back(v(0,0,32'h0,   1, 0,32'h0,   32'h0,        32'h0,   32'd400, 1,2'd2,0));
    vt.push_back(v(0,1,32'h0,   1, 0,32'h0,   32'h0,        32'h0,   32'h0,   0,2'd0,0));
    vt.push_back(v(0,0,32'h0,   1, 1,32'h0,   32'h1111_1111,32'h4,   32'h4,   0,2'd0,1));
    vt.push_back(v(1,1,32'h80,  1, 0,32'h0,   32'h0,        32'h0,   32'h0,   0,2'd0,1));
    vt.push_back(v(0,0,32'h0,   1, 1,32'h0,   32'h1111_1111,32'h4,   32'h4,   0,2'd0,1));

    foreach (vt[k]) begin
      tick(vt[k].r, vt[k].rv, vt[k].rpc, vt[k].rdy);
      chk($sformatf("vec%0d.valid", k), {31'h0, out_valid}, {31'h0, vt[k].ev});
      chk($sformatf("vec%0d.addr", k), imem_addr, vt[k].eaddr);
      chk($sformatf("vec%0d.fault", k), {31'h0, fault}, {31'h0, vt[k].ef});
      chk($sformatf("vec%0d.cause", k), {30'h0, fault_cause}, {30'h0, vt[k].ec});
      if (vt[k].cd) begin
        chk($sformatf("vec%0d.instr", k), out_instr, vt[k].einstr);
        chk($sformatf("vec%0d.pc", k), out_pc, vt[k].epc);
        chk($sformatf("vec%0d.pc4", k), out_pc_plus4, vt[k].ep4);
      end
    end

    // Randomized traffic against the behavioural model.
    model_step(1'b1, 1'b0, 32'h0, 1'b0);
    tick(1'b1, 1'b0, 32'h0, 1'b0);
    for (int c = 0; c < 3000; c++) begin
      r   = ($urandom_range(0, 199) == 0);
      rv  = ($urandom_range(0, 19) == 0);
      rdy = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 3))
        0:       tgt = 32'($urandom_range(0, 99)) * 32'd4;
        1:       tgt = (32'($urandom_range(0, 99)) * 32'd4) | 32'($urandom_range(1, 3));
        2:       tgt = 32'd400 + 32'($urandom_range(0, 1000)) * 32'd4;
        default: tgt = 32'd380 + 32'($urandom_range(0, 4)) * 32'd4;
      endcase
      model_step(r, rv, tgt, rdy);
      tick(r, rv, tgt, rdy);
      chk("rnd.valid", {31'h0, out_valid}, {31'h0, m_valid});
      chk("rnd.addr", imem_addr, m_pc);
      chk("rnd.fault", {31'h0, fault}, {31'h0, m_fault});
      chk("rnd.cause", {30'h0, fault_cause}, {30'h0, m_cause});
      if (m_valid) begin
        chk("rnd.instr", out_instr, m_sinstr);
        chk("rnd.pc", out_pc, m_spc);
        chk("rnd.pc4", out_pc_plus4, m_spc + 32'd4);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
